// File: rtl/window_buffer.sv
// window_buffer: 3x3 pixel window for the Sobel datapath; loads pixels bottom row first and slides on shift commands.
// Build option: define WINDOW_SHIFT_ZERO_FILL_EN to clear the vacated column/row on every shift.
module window_buffer #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_shift,
    input  logic             start_read,
    input  logic [1:0]       shift_direc,
    input  logic [PIX_W-1:0] data_r,
    input  logic [3:0]       count,
    output logic             read_done,
    output logic             shift_done,
    output logic [PIX_W-1:0] windowBufferOut [0:8],
    output logic [3:0]       count_o
);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    logic [PIX_W-1:0] win_r     [0:8];
    logic [PIX_W-1:0] win_nxt_s [0:8];
    logic             read_done_r;
    logic             read_done_nxt_s;
    logic             shift_done_r;
    logic             shift_done_nxt_s;
    logic [3:0]       count_r;
    logic [3:0]       count_nxt_s;
    logic [3:0]       slot_s;

    // Value left behind in the column or row that a shift vacates.
    function automatic logic [PIX_W-1:0] vacated(input logic [PIX_W-1:0] old);
`ifdef WINDOW_SHIFT_ZERO_FILL_EN
        vacated = old & {PIX_W{1'b0}};
`else
        vacated = old;
`endif
    endfunction

    // Load index to window slot: bottom row first, then middle, then top.
    function automatic logic [3:0] slot_of(input logic [3:0] idx);
        case (idx)
            4'd0:    slot_of = 4'd6;
            4'd1:    slot_of = 4'd7;
            4'd2:    slot_of = 4'd8;
            4'd3:    slot_of = 4'd3;
            4'd4:    slot_of = 4'd4;
            4'd5:    slot_of = 4'd5;
            4'd6:    slot_of = 4'd0;
            4'd7:    slot_of = 4'd1;
            4'd8:    slot_of = 4'd2;
            default: slot_of = 4'd0;
        endcase
    endfunction

    // Next-state logic: a shift takes priority over a simultaneous read.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_nxt_s[i] = win_r[i];
        end
        read_done_nxt_s  = 1'b0;
        shift_done_nxt_s = 1'b0;
        count_nxt_s      = count_r;
        slot_s           = slot_of(count);

        if (start_shift) begin
            shift_done_nxt_s = 1'b1;
            case (shift_direc)
                DIR_RIGHT: begin
                    for (int r = 0; r < 3; r++) begin
                        win_nxt_s[3*r+2] = win_r[3*r+1];
                        win_nxt_s[3*r+1] = win_r[3*r];
                        win_nxt_s[3*r]   = vacated(win_r[3*r]);
                    end
                end
                DIR_LEFT: begin
                    for (int r = 0; r < 3; r++) begin
                        win_nxt_s[3*r]   = win_r[3*r+1];
                        win_nxt_s[3*r+1] = win_r[3*r+2];
                        win_nxt_s[3*r+2] = vacated(win_r[3*r+2]);
                    end
                end
                DIR_UP: begin
                    for (int c = 0; c < 3; c++) begin
                        win_nxt_s[c]   = win_r[3+c];
                        win_nxt_s[3+c] = win_r[6+c];
                        win_nxt_s[6+c] = vacated(win_r[6+c]);
                    end
                end
                DIR_DOWN: begin
                    for (int c = 0; c < 3; c++) begin
                        win_nxt_s[6+c] = win_r[3+c];
                        win_nxt_s[3+c] = win_r[c];
                        win_nxt_s[c]   = vacated(win_r[c]);
                    end
                end
                default: begin
                    shift_done_nxt_s = 1'b1;
                end
            endcase
        end else if (start_read) begin
            if (count <= 4'd8) begin
                for (int i = 0; i < 9; i++) begin
                    if (slot_s == 4'(i)) begin
                        win_nxt_s[i] = data_r;
                    end else begin
                        win_nxt_s[i] = win_r[i];
                    end
                end
                read_done_nxt_s = 1'b1;
                count_nxt_s     = (count == 4'd8) ? 4'd0 : count + 4'd1;
            end else begin
                count_nxt_s = 4'd0;
            end
        end else begin
            read_done_nxt_s  = 1'b0;
            shift_done_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= {PIX_W{1'b0}};
            end
            read_done_r  <= 1'b0;
            shift_done_r <= 1'b0;
            count_r      <= 4'd0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= win_nxt_s[i];
            end
            read_done_r  <= read_done_nxt_s;
            shift_done_r <= shift_done_nxt_s;
            count_r      <= count_nxt_s;
        end
    end

    assign windowBufferOut = win_r;
    assign read_done       = read_done_r;
    assign shift_done      = shift_done_r;
    assign count_o         = count_r;

endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: directed and randomized checks of window_buffer against a row/column reference model.
// Honours WINDOW_SHIFT_ZERO_FILL_EN in the model; literal window checks apply to the default build.
module tb_window_buffer;

    localparam int PIX_W = 8;

    logic             tb_clk = 1'b0;
    logic             n_rst;
    logic             start_shift;
    logic             start_read;
    logic [1:0]       shift_direc;
    logic [PIX_W-1:0] data_r;
    logic [3:0]       count;
    logic             read_done;
    logic             shift_done;
    logic [PIX_W-1:0] windowBufferOut [0:8];
    logic [3:0]       count_o;

    window_buffer #(.PIX_W(PIX_W)) dut (
        .clk             (tb_clk),
        .n_rst           (n_rst),
        .start_shift     (start_shift),
        .start_read      (start_read),
        .shift_direc     (shift_direc),
        .data_r          (data_r),
        .count           (count),
        .read_done       (read_done),
        .shift_done      (shift_done),
        .windowBufferOut (windowBufferOut),
        .count_o         (count_o)
    );

    always #5 tb_clk = ~tb_clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: window as m[row][col], row 0 = top.
    logic [7:0] m [0:2][0:2];
    logic [3:0] m_count;
    logic       m_rd;
    logic       m_sd;

    function automatic logic [7:0] fillv(input logic [7:0] old);
`ifdef WINDOW_SHIFT_ZERO_FILL_EN
        return 8'd0;
`else
        return old;
`endif
    endfunction

    task automatic model_edge(input logic rst, input logic sr, input logic ss,
                              input logic [1:0] dir, input logic [7:0] d, input logic [3:0] c);
        logic [7:0] t [0:2][0:2];
        t = m;
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++) m[r][k] = 8'd0;
            m_count = 4'd0; m_rd = 1'b0; m_sd = 1'b0;
        end else if (ss) begin
            m_rd = 1'b0; m_sd = 1'b1;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    case (dir)
                        2'b00: m[r][k] = (k == 0) ? fillv(t[r][0]) : t[r][k-1];
                        2'b01: m[r][k] = (k == 2) ? fillv(t[r][2]) : t[r][k+1];
                        2'b10: m[r][k] = (r == 2) ? fillv(t[2][k]) : t[r+1][k];
                        default: m[r][k] = (r == 0) ? fillv(t[0][k]) : t[r-1][k];
                    endcase
                end
            end
        end else if (sr) begin
            m_sd = 1'b0;
            if (c <= 4'd8) begin
                m[2 - int'(c) / 3][int'(c) % 3] = d;
                m_rd = 1'b1;
                m_count = 4'((int'(c) + 1) % 9);
            end else begin
                m_rd = 1'b0;
                m_count = 4'd0;
            end
        end else begin
            m_rd = 1'b0; m_sd = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s win[%0d]", tag, i), 72'(windowBufferOut[i]), 72'(m[i/3][i%3]));
        chk({tag, " read_done"}, 72'(read_done), 72'(m_rd));
        chk({tag, " shift_done"}, 72'(shift_done), 72'(m_sd));
        chk({tag, " count_o"}, 72'(count_o), 72'(m_count));
    endtask

    function automatic logic [71:0] dut_packed();
        logic [71:0] p;
        for (int i = 0; i < 9; i++) p[71-8*i -: 8] = windowBufferOut[i];
        return p;
    endfunction

    task automatic step(input string tag, input logic rst, input logic sr, input logic ss,
                        input logic [1:0] dir, input logic [7:0] d, input logic [3:0] c);
        n_rst = rst; start_read = sr; start_shift = ss; shift_direc = dir; data_r = d; count = c;
        @(posedge tb_clk);
        model_edge(rst, sr, ss, dir, d, c);
        #1;
        check_all(tag);
    endtask

    // Nine reads giving window 0..8, count taken from the model's count_o.
    task automatic load_full();
        logic [7:0] seq [0:8];
        seq = '{8'd6, 8'd7, 8'd8, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        for (int k = 0; k < 9; k++) step("load", 1'b0, 1'b1, 1'b0, 2'b00, seq[k], m_count);
    endtask

    initial begin
        n_rst = 1'b1; start_read = 1'b0; start_shift = 1'b0;
        shift_direc = 2'b00; data_r = 8'd0; count = 4'd0;
        m_count = 4'd0; m_rd = 1'b0; m_sd = 1'b0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++) m[r][k] = 8'hxx;

        step("reset", 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 4'd0);
        step("reset2", 1'b1, 1'b1, 1'b1, 2'b01, 8'd55, 4'd3);

        step("read0", 1'b0, 1'b1, 1'b0, 2'b00, 8'd6, 4'd0);
        chk("read0 literal", dut_packed(), {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd0, 8'd0});
        chk("read0 count_o literal", 72'(count_o), 72'd1);
        step("idle", 1'b0, 1'b0, 1'b0, 2'b00, 8'd99, 4'd5);

        step("reset3", 1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 4'd0);
        load_full();
        chk("full literal", dut_packed(), {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        chk("full count_o wrap", 72'(count_o), 72'd0);

        step("shift left", 1'b0, 1'b0, 1'b1, 2'b01, 8'd0, 4'd0);
`ifndef WINDOW_SHIFT_ZERO_FILL_EN
        chk("shift left literal", dut_packed(), {8'd1, 8'd2, 8'd2, 8'd4, 8'd5, 8'd5, 8'd7, 8'd8, 8'd8});
`endif
        step("after shift", 1'b0, 1'b0, 1'b0, 2'b00, 8'd0, 4'd0);

        load_full();
        step("shift up", 1'b0, 1'b0, 1'b1, 2'b10, 8'd0, 4'd0);
`ifndef WINDOW_SHIFT_ZERO_FILL_EN
        chk("shift up literal", dut_packed(), {8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd6, 8'd7, 8'd8});
`endif
        load_full();
        step("shift down", 1'b0, 1'b0, 1'b1, 2'b11, 8'd0, 4'd0);
`ifndef WINDOW_SHIFT_ZERO_FILL_EN
        chk("shift down literal", dut_packed(), {8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
`endif
        load_full();
        step("read+shift right", 1'b0, 1'b1, 1'b1, 2'b00, 8'd77, 4'd0);
`ifndef WINDOW_SHIFT_ZERO_FILL_EN
        chk("read+shift literal", dut_packed(), {8'd0, 8'd0, 8'd1, 8'd3, 8'd3, 8'd4, 8'd6, 8'd6, 8'd7});
`endif
        step("held shift", 1'b0, 1'b0, 1'b1, 2'b00, 8'd0, 4'd0);
        step("held shift2", 1'b0, 1'b0, 1'b1, 2'b01, 8'd0, 4'd0);

        for (int k = 0; k < 4; k++)
            step("partial load", 1'b0, 1'b1, 1'b0, 2'b00, 8'(8'd20 + k), m_count);
        step("mid-load reset", 1'b1, 1'b1, 1'b0, 2'b00, 8'd33, m_count);
        chk("mid-load reset literal", dut_packed(), 72'd0);

        step("read c0", 1'b0, 1'b1, 1'b0, 2'b00, 8'd11, 4'd0);
        step("read c9", 1'b0, 1'b1, 1'b0, 2'b00, 8'hAA, 4'd9);
        step("read c15", 1'b0, 1'b1, 1'b0, 2'b00, 8'hBB, 4'd15);

        for (int n = 0; n < 600; n++) begin
            logic       rst, sr, ss;
            logic [3:0] c;
            rst = ($urandom_range(0, 49) == 0);
            sr  = 1'($urandom);
            ss  = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : m_count;
            step("random", rst, sr, ss, 2'($urandom), 8'($urandom), c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
